// File: rtl/serial_display_sequencer_if.sv
// Client-side handshake and serial display bus for serial_display_sequencer.
// i_blank_mask exists only when DISPLAY_BLANK_EN is defined.
interface serial_display_sequencer_if #(
  parameter int unsigned NUM_BITS = 32
);
  logic                i_en;
  logic                i_req;
  logic [NUM_BITS-1:0] i_data;
`ifdef DISPLAY_BLANK_EN
  logic [3:0]          i_blank_mask;
`endif
  logic                o_busy;
  logic                o_done;
  logic                o_serial_data;
  logic                o_serial_latch;
  logic                o_serial_clk;

  modport master (
`ifdef DISPLAY_BLANK_EN
    output i_blank_mask,
`endif
    output i_en, i_req, i_data,
    input  o_busy, o_done, o_serial_data, o_serial_latch, o_serial_clk
  );

  modport slave (
`ifdef DISPLAY_BLANK_EN
    input  i_blank_mask,
`endif
    input  i_en, i_req, i_data,
    output o_busy, o_done, o_serial_data, o_serial_latch, o_serial_clk
  );
endinterface

// File: rtl/serial_display_sequencer.sv
// Shifts 32-bit segment frames MSB-first onto a 3-wire data/latch/clk display chain.
// Optional per-digit blanking when DISPLAY_BLANK_EN is defined.
module serial_display_sequencer #(
  parameter int unsigned SYS_CLK_HZ   = 5_000_000,
  parameter int unsigned SHIFT_CLK_HZ = 1_000_000,
  parameter int unsigned NUM_BITS     = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  serial_display_sequencer_if.slave bus
);
  localparam int unsigned DIV_RAW = SYS_CLK_HZ / (2 * SHIFT_CLK_HZ);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned PH_W    = $clog2(DIV) + 1;
  localparam int unsigned BIT_W   = $clog2(NUM_BITS) + 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [NUM_BITS-1:0] hold_q, hold_d;
  logic                pending_q, pending_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                clk_hi_q, clk_hi_d;
  logic [NUM_BITS-1:0] frame_in;

`ifdef DISPLAY_BLANK_EN
  always_comb begin
    frame_in = bus.i_data;
    for (int unsigned n = 0; n < NUM_BITS / 8 && n < 4; n++) begin
      if (bus.i_blank_mask[n]) frame_in[8*n +: 8] = '0;
    end
  end
`else
  always_comb frame_in = bus.i_data;
`endif

  // All state advances only on enabled cycles, so i_en=0 freezes everything.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      hold_q    <= '0;
      pending_q <= 1'b0;
      phase_q   <= '0;
      bit_q     <= '0;
      clk_hi_q  <= 1'b0;
    end else if (bus.i_en) begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      clk_hi_q  <= clk_hi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    clk_hi_d  = clk_hi_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_req) begin
          shift_d  = frame_in;
          phase_d  = '0;
          bit_d    = '0;
          clk_hi_d = 1'b0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bus.i_req) begin
          hold_d    = frame_in;
          pending_d = 1'b1;
        end
        if (phase_q == PH_LAST) begin
          phase_d  = '0;
          clk_hi_d = !clk_hi_q;
          // End of the high phase: advance to the next bit so data changes with clk low.
          if (clk_hi_q) begin
            shift_d = {shift_q[NUM_BITS-2:0], 1'b0};
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = S_LATCH;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_LATCH: begin
        if (bus.i_req) begin
          hold_d    = frame_in;
          pending_d = 1'b1;
        end
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          state_d = S_DONE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_DONE: begin
        // A request arriving in DONE is newer than the hold register, so it wins.
        if (bus.i_req || pending_q) begin
          shift_d   = bus.i_req ? frame_in : hold_q;
          pending_d = 1'b0;
          phase_d   = '0;
          bit_d     = '0;
          clk_hi_d  = 1'b0;
          state_d   = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_busy         = (state_q == S_SHIFT) || (state_q == S_LATCH);
    bus.o_done         = (state_q == S_DONE);
    bus.o_serial_clk   = (state_q == S_SHIFT) && clk_hi_q;
    bus.o_serial_data  = (state_q == S_SHIFT) && shift_q[NUM_BITS-1];
    bus.o_serial_latch = (state_q == S_LATCH);
  end
endmodule

// File: tb/tb_serial_display_sequencer.sv
// Directed bench for serial_display_sequencer: default DIV=2 instance and a DIV=1 instance.
module tb_serial_display_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  serial_display_sequencer_if #(.NUM_BITS(32)) bus_d ();
  serial_display_sequencer_if #(.NUM_BITS(32)) bus_f ();

  serial_display_sequencer #(
    .SYS_CLK_HZ(5_000_000), .SHIFT_CLK_HZ(1_000_000), .NUM_BITS(32)
  ) dut_d (.i_clk(clk), .i_reset_n(rst_n), .bus(bus_d));

  serial_display_sequencer #(
    .SYS_CLK_HZ(5_000_000), .SHIFT_CLK_HZ(2_500_000), .NUM_BITS(32)
  ) dut_f (.i_clk(clk), .i_reset_n(rst_n), .bus(bus_f));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // {busy, done, serial_data, serial_latch, serial_clk}
  function automatic logic [4:0] outs(input bit fast);
    if (fast)
      return {bus_f.o_busy, bus_f.o_done, bus_f.o_serial_data, bus_f.o_serial_latch, bus_f.o_serial_clk};
    return {bus_d.o_busy, bus_d.o_done, bus_d.o_serial_data, bus_d.o_serial_latch, bus_d.o_serial_clk};
  endfunction

  task automatic set_in(input bit fast, input logic en, input logic req, input logic [31:0] data);
    if (fast) begin
      bus_f.i_en = en; bus_f.i_req = req; bus_f.i_data = data;
    end else begin
      bus_d.i_en = en; bus_d.i_req = req; bus_d.i_data = data;
    end
  endtask

  task automatic start_frame(input bit fast, input logic [31:0] data);
    set_in(fast, 1'b1, 1'b1, data);
    step();
    set_in(fast, 1'b1, 1'b0, data);
    cyc = 1;
  endtask

  task automatic run_frame(input bit fast, input int freeze_at, input int freeze_len,
                           input int abort_at, output logic [31:0] bits, output int nrise,
                           output int latch_first, output int latch_last,
                           output int done_cyc, output int viol);
    logic [4:0] o;
    logic [4:0] snap = '0;
    logic prev_clk = 1'b0;
    bits = '0; nrise = 0; latch_first = -1; latch_last = -1; done_cyc = -1; viol = 0;
    for (int n = 0; n < 400; n++) begin
      o = outs(fast);
      if (cyc > freeze_at && cyc <= freeze_at + freeze_len) begin
        if (o !== snap) viol++;
      end else begin
        if (o[3]) begin
          done_cyc = cyc;
          break;
        end
        if (!o[4]) viol++;
        if (o[0] && !prev_clk) begin
          bits = {bits[30:0], o[2]};
          nrise++;
        end
        if (o[1]) begin
          if (latch_first < 0) latch_first = cyc;
          latch_last = cyc;
          if (o[0] || o[2]) viol++;
        end
        prev_clk = o[0];
      end
      if (cyc == abort_at) break;
      if (cyc == freeze_at) begin
        snap = o;
        set_in(fast, 1'b0, 1'b1, 32'hFFFF_FFFF);
      end
      if (cyc == freeze_at + freeze_len) set_in(fast, 1'b1, 1'b0, 32'h0);
      step();
    end
  endtask

  logic [31:0] bits;
  logic [4:0]  o;
  int nrise, lf, ll, dc, viol, bad;

  initial begin
    rst_n = 1'b0;
    set_in(0, 1'b1, 1'b0, 32'h0);
    set_in(1, 1'b1, 1'b0, 32'h0);
`ifdef DISPLAY_BLANK_EN
    bus_d.i_blank_mask = 4'b0000;
    bus_f.i_blank_mask = 4'b0000;
`endif
    step(); step();
    check("reset_outs_div2", 32'(outs(0)), 32'h0);
    check("reset_outs_div1", 32'(outs(1)), 32'h0);
    rst_n = 1'b1;
    step();

    // 1: basic frame
    start_frame(0, 32'hA5C3_0F81);
    o = outs(0);
    check("t1_busy_c1", 32'(o[4]), 32'h1);
    check("t1_data_c1", 32'(o[2]), 32'h1);
    run_frame(0, -1, 0, -1, bits, nrise, lf, ll, dc, viol);
    check("t1_bits", bits, 32'hA5C3_0F81);
    check("t1_rises", 32'(nrise), 32'd32);
    check("t1_latch_first", 32'(lf), 32'd129);
    check("t1_latch_last", 32'(ll), 32'd130);
    check("t1_done_cyc", 32'(dc), 32'd131);
    check("t1_viol", 32'(viol), 32'd0);
    step();
    check("t1_idle_busy", 32'(outs(0)), 32'h0);
    step();

    // 2: two requests during SHIFT, latest wins, no idle gap
    start_frame(0, 32'hA5A5_0000);
    while (cyc < 10) step();
    set_in(0, 1'b1, 1'b1, 32'h1111_1111);
    step();
    set_in(0, 1'b1, 1'b1, 32'h2222_2222);
    step();
    set_in(0, 1'b1, 1'b0, 32'h0);
    run_frame(0, -1, 0, -1, bits, nrise, lf, ll, dc, viol);
    check("t2_done1_cyc", 32'(dc), 32'd131);
    check("t2_done1_busy", 32'(outs(0) >> 4), 32'h0);
    step();
    check("t2_resume_busy", 32'(outs(0) >> 4), 32'h1);
    run_frame(0, -1, 0, -1, bits, nrise, lf, ll, dc, viol);
    check("t2_bits", bits, 32'h2222_2222);
    check("t2_done2_cyc", 32'(dc), 32'd262);
    check("t2_viol", 32'(viol), 32'd0);
    step();
    check("t2_idle_after", 32'(outs(0) >> 4), 32'h0);
    step();

    // 3: freeze 10 cycles inside bit 7; req during freeze ignored
    start_frame(0, 32'h3C5A_96E1);
    run_frame(0, 30, 10, -1, bits, nrise, lf, ll, dc, viol);
    check("t3_bits", bits, 32'h3C5A_96E1);
    check("t3_rises", 32'(nrise), 32'd32);
    check("t3_done_cyc", 32'(dc), 32'd141);
    check("t3_viol", 32'(viol), 32'd0);
    step();
    check("t3_idle_after", 32'(outs(0) >> 4), 32'h0);
    step();

    // 4: reset during bit 20
    start_frame(0, 32'hFFFF_FFFF);
    run_frame(0, -1, 0, 82, bits, nrise, lf, ll, dc, viol);
    check("t4_pre_abort_busy", 32'(outs(0) >> 4), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t4_abort_outs", 32'(outs(0)), 32'h0);
    step(); step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 140; i++) begin
      step();
      if (outs(0) !== 5'b0) bad++;
    end
    check("t4_no_latch_after", 32'(bad), 32'd0);
    start_frame(0, 32'h0123_4567);
    run_frame(0, -1, 0, -1, bits, nrise, lf, ll, dc, viol);
    check("t4_post_bits", bits, 32'h0123_4567);
    check("t4_post_done", 32'(dc), 32'd131);
    step(); step();

    // 5: DIV=1 instance
    start_frame(1, 32'hDEAD_BEEF);
    run_frame(1, -1, 0, -1, bits, nrise, lf, ll, dc, viol);
    check("t5_bits", bits, 32'hDEAD_BEEF);
    check("t5_rises", 32'(nrise), 32'd32);
    check("t5_latch_first", 32'(lf), 32'd65);
    check("t5_latch_last", 32'(ll), 32'd65);
    check("t5_done_cyc", 32'(dc), 32'd66);
    step(); step();

    // 6: digit blanking
`ifdef DISPLAY_BLANK_EN
    bus_d.i_blank_mask = 4'b0101;
`endif
    start_frame(0, 32'hFFFF_FFFF);
`ifdef DISPLAY_BLANK_EN
    bus_d.i_blank_mask = 4'b0000;
`endif
    run_frame(0, -1, 0, -1, bits, nrise, lf, ll, dc, viol);
`ifdef DISPLAY_BLANK_EN
    check("t6_blank_bits", bits, 32'hFF00_FF00);
`else
    check("t6_plain_bits", bits, 32'hFFFF_FFFF);
`endif
    check("t6_done_cyc", 32'(dc), 32'd131);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
